datapath_seq: RTL and testbench

Parametrised, self-sequencing successor to the CPU datapath. It contains a register file, the A/B/C operand and result registers, a shifter, an ALU and the writeback mux. It accepts one command per start/ready handshake and steps itself through read-A, read-B, execute and writeback, replacing the per-cycle load strobes the top-level FSM used to drive. It also adds a carry flag, an arithmetic right shift and width/depth parameters.

---
 rtl/datapath_seq_pkg.sv | 27 ++
 rtl/datapath_seq_regfile.sv | 33 +++
 rtl/datapath_seq.sv | 202 ++++++++++++++++++++
 tb/tb_datapath_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_seq_pkg.sv
// rtl/datapath_seq_pkg.sv - shared state, opcode and writeback-select definitions for datapath_seq
package datapath_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RDA  = 3'd1,
        RDB  = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4
    } dp_state_e;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    localparam int VS_MDATA = 3;
    localparam int VS_IMM8  = 2;
    localparam int VS_PC    = 1;
    localparam int VS_C     = 0;

endpackage

// File: rtl/datapath_seq_regfile.sv
// rtl/datapath_seq_regfile.sv - register file with one sync write port, operand and debug read ports
module dp_regfile #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    localparam int RW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [RW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [RW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o,
    input  logic [RW-1:0]    dbg_raddr_i,
    output logic [WIDTH-1:0] dbg_rdata_o
);

    logic [WIDTH-1:0] mem_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o     = mem_q[raddr_i];
    assign dbg_rdata_o = mem_q[dbg_raddr_i];

endmodule

// File: rtl/datapath_seq.sv
// rtl/datapath_seq.sv - self-sequencing datapath: read A, read B, execute, writeback per command
module datapath_seq
    import datapath_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int PC_W  = 9,
    localparam int RW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ready,
    input  logic [RW-1:0]    rd,
    input  logic [RW-1:0]    rn,
    input  logic [RW-1:0]    rm,
    input  logic [1:0]       shift,
    input  logic [1:0]       alu_op,
    input  logic             asel,
    input  logic             bsel,
    input  logic [3:0]       vsel,
    input  logic             wb_en,
    input  logic             flags_en,
    input  logic [WIDTH-1:0] mdata,
    input  logic [WIDTH-1:0] sximm8,
    input  logic [WIDTH-1:0] sximm5,
    input  logic [PC_W-1:0]  pc,
    input  logic [RW-1:0]    dbg_rnum,
    output logic [WIDTH-1:0] dbg_data,
    output logic [WIDTH-1:0] datapath_out,
    output logic             z_out,
    output logic             n_out,
    output logic             v_out,
    output logic             c_out,
    output logic             done
);

    dp_state_e        state_q;
    logic             ready_q, done_q;

    logic [RW-1:0]    rd_q, rn_q, rm_q;
    logic [1:0]       shift_q, alu_op_q;
    logic             asel_q, bsel_q, wb_en_q, flags_en_q;
    logic [3:0]       vsel_q;

    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic             z_q, n_q, v_q, cf_q;

    logic [WIDTH-1:0] rf_rdata, wb_data;
    logic [WIDTH-1:0] b_shifted, ain, bin, c_d;
    logic [WIDTH:0]   sum_ext, diff_ext;
    logic             z_d, n_d, v_d, cf_d;

    // One shared operand read port: rn while reading A, rm otherwise.
    dp_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       ((state_q == WB) && wb_en_q),
        .waddr_i    (rd_q),
        .wdata_i    (wb_data),
        .raddr_i    ((state_q == RDA) ? rn_q : rm_q),
        .rdata_o    (rf_rdata),
        .dbg_raddr_i(dbg_rnum),
        .dbg_rdata_o(dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            rd_q       <= '0;
            rn_q       <= '0;
            rm_q       <= '0;
            shift_q    <= '0;
            alu_op_q   <= '0;
            asel_q     <= 1'b0;
            bsel_q     <= 1'b0;
            vsel_q     <= '0;
            wb_en_q    <= 1'b0;
            flags_en_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RDA;
                        ready_q    <= 1'b0;
                        rd_q       <= rd;
                        rn_q       <= rn;
                        rm_q       <= rm;
                        shift_q    <= shift;
                        alu_op_q   <= alu_op;
                        asel_q     <= asel;
                        bsel_q     <= bsel;
                        vsel_q     <= vsel;
                        wb_en_q    <= wb_en;
                        flags_en_q <= flags_en;
                    end
                end
                RDA:  state_q <= RDB;
                RDB:  state_q <= EXEC;
                EXEC: begin
                    state_q <= WB;
                    done_q  <= 1'b1;
                end
                WB: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        b_shifted = b_q;
        unique case (shift_q)
            SH_NONE: b_shifted = b_q;
            SH_LSL:  b_shifted = {b_q[WIDTH-2:0], 1'b0};
            SH_LSR:  b_shifted = {1'b0, b_q[WIDTH-1:1]};
            SH_ASR:  b_shifted = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
            default: b_shifted = b_q;
        endcase
    end

    assign ain      = asel_q ? '0 : a_q;
    assign bin      = bsel_q ? sximm5 : b_shifted;
    assign sum_ext  = {1'b0, ain} + {1'b0, bin};
    assign diff_ext = {1'b0, ain} - {1'b0, bin};

    // Carry for SUB is NOT borrow, i.e. set when A >= B unsigned.
    always_comb begin
        c_d  = '0;
        v_d  = 1'b0;
        cf_d = 1'b0;
        unique case (alu_op_q)
            ALU_ADD: begin
                c_d  = sum_ext[WIDTH-1:0];
                cf_d = sum_ext[WIDTH];
                v_d  = (ain[WIDTH-1] == bin[WIDTH-1]) && (c_d[WIDTH-1] != ain[WIDTH-1]);
            end
            ALU_SUB: begin
                c_d  = diff_ext[WIDTH-1:0];
                cf_d = ~diff_ext[WIDTH];
                v_d  = (ain[WIDTH-1] != bin[WIDTH-1]) && (c_d[WIDTH-1] != ain[WIDTH-1]);
            end
            ALU_AND: c_d = ain & bin;
            ALU_NOT: c_d = ~bin;
            default: c_d = '0;
        endcase
        z_d = (c_d == '0);
        n_d = c_d[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            c_q  <= '0;
            z_q  <= 1'b0;
            n_q  <= 1'b0;
            v_q  <= 1'b0;
            cf_q <= 1'b0;
        end else begin
            if (state_q == RDA) a_q <= rf_rdata;
            if (state_q == RDB) b_q <= rf_rdata;
            if (state_q == EXEC) begin
                c_q <= c_d;
                if (flags_en_q) begin
                    z_q  <= z_d;
                    n_q  <= n_d;
                    v_q  <= v_d;
                    cf_q <= cf_d;
                end
            end
        end
    end

    always_comb begin
        wb_data = c_q;
        casez (vsel_q)
            4'b1???: wb_data = mdata;
            4'b01??: wb_data = sximm8;
            4'b001?: wb_data = WIDTH'(pc);
            default: wb_data = c_q;
        endcase
    end

    assign ready        = ready_q;
    assign done         = done_q;
    assign datapath_out = c_q;
    assign z_out        = z_q;
    assign n_out        = n_q;
    assign v_out        = v_q;
    assign c_out        = cf_q;

endmodule

// File: tb/tb_datapath_seq.sv
// tb/tb_datapath_seq.sv - directed self-checking bench for datapath_seq
module tb_datapath_seq;
    import datapath_seq_pkg::*;

    localparam int WIDTH = 16;
    localparam int NREGS = 8;
    localparam int PC_W  = 9;
    localparam int RW    = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             ready, done;
    logic [RW-1:0]    rd = '0, rn = '0, rm = '0, dbg_rnum = '0;
    logic [1:0]       shift = '0, alu_op = '0;
    logic             asel = 1'b0, bsel = 1'b0, wb_en = 1'b0, flags_en = 1'b0;
    logic [3:0]       vsel = '0;
    logic [WIDTH-1:0] mdata = '0, sximm8 = '0, sximm5 = '0;
    logic [PC_W-1:0]  pc = '0;
    logic [WIDTH-1:0] dbg_data, datapath_out;
    logic             z_out, n_out, v_out, c_out;

    int n_cmp = 0;
    int n_err = 0;
    int ndone;
    logic [WIDTH-1:0] exp_r [NREGS];

    datapath_seq #(.WIDTH(WIDTH), .NREGS(NREGS), .PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
        .rd(rd), .rn(rn), .rm(rm), .shift(shift), .alu_op(alu_op),
        .asel(asel), .bsel(bsel), .vsel(vsel), .wb_en(wb_en), .flags_en(flags_en),
        .mdata(mdata), .sximm8(sximm8), .sximm5(sximm5), .pc(pc),
        .dbg_rnum(dbg_rnum), .dbg_data(dbg_data), .datapath_out(datapath_out),
        .z_out(z_out), .n_out(n_out), .v_out(v_out), .c_out(c_out), .done(done)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int r = 0; r < NREGS; r++) begin
            dbg_rnum = RW'(r);
            #1;
            chk($sformatf("%s R%0d", tag, r), dbg_data, exp_r[r]);
        end
    endtask

    task automatic chk_flags(input string tag, input logic z, input logic n, input logic v, input logic c);
        chk({tag, " flags"}, {12'h0, z_out, n_out, v_out, c_out}, {12'h0, z, n, v, c});
    endtask

    task automatic clear_model();
        for (int r = 0; r < NREGS; r++) exp_r[r] = '0;
    endtask

    // Issues one command from IDLE and checks the done/ready timing around it.
    task automatic do_cmd(input logic [RW-1:0] f_rd, input logic [RW-1:0] f_rn, input logic [RW-1:0] f_rm,
                          input logic [1:0] f_sh, input logic [1:0] f_alu, input logic f_asel,
                          input logic f_bsel, input logic [3:0] f_vsel, input logic f_wb, input logic f_fl);
        @(negedge clk);
        rd = f_rd; rn = f_rn; rm = f_rm; shift = f_sh; alu_op = f_alu;
        asel = f_asel; bsel = f_bsel; vsel = f_vsel; wb_en = f_wb; flags_en = f_fl;
        chk("ready_idle", {15'h0, ready}, 16'h1);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rd = f_rd + 1'b1; rn = f_rn + 1'b1; rm = f_rm + 1'b1; shift = ~f_sh; alu_op = ~f_alu;
        asel = ~f_asel; bsel = ~f_bsel; vsel = ~f_vsel; wb_en = ~f_wb; flags_en = ~f_fl;
        for (int i = 0; i < 3; i++) begin
            chk("done_early", {15'h0, done}, 16'h0);
            @(negedge clk);
        end
        chk("done_wb", {15'h0, done}, 16'h1);
        chk("ready_wb", {15'h0, ready}, 16'h0);
        @(negedge clk);
        chk("done_after", {15'h0, done}, 16'h0);
        chk("ready_after", {15'h0, ready}, 16'h1);
    endtask

    task automatic load(input logic [RW-1:0] r, input logic [WIDTH-1:0] val);
        sximm8 = val;
        do_cmd(r, '0, '0, SH_NONE, ALU_ADD, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0);
        exp_r[r] = val;
    endtask

    initial begin
        clear_model();
        repeat (2) @(negedge clk);
        chk("rst ready", {15'h0, ready}, 16'h1);
        chk("rst done", {15'h0, done}, 16'h0);
        chk("rst dout", datapath_out, 16'h0);
        chk_flags("rst", 0, 0, 0, 0);
        chk_regs("rst");
        rst_n = 1'b1;

        load(3'd3, 16'h0007);
        chk_regs("imm8");
        chk_flags("imm8", 0, 0, 0, 0);

        load(3'd1, 16'h7FFF);
        load(3'd2, 16'h0001);
        do_cmd(3'd4, 3'd1, 3'd2, SH_NONE, ALU_ADD, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1);
        exp_r[4] = 16'h8000;
        chk("ovf dout", datapath_out, 16'h8000);
        chk_flags("ovf", 0, 1, 1, 0);
        chk_regs("ovf");

        load(3'd6, 16'hFFFF);
        do_cmd(3'd7, 3'd6, 3'd2, SH_NONE, ALU_ADD, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1);
        exp_r[7] = 16'h0000;
        chk_flags("carry", 1, 0, 0, 1);
        chk_regs("carry");

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        clear_model();
        chk("mrst ready", {15'h0, ready}, 16'h1);
        chk("mrst done", {15'h0, done}, 16'h0);
        chk("mrst dout", datapath_out, 16'h0);
        chk_flags("mrst", 0, 0, 0, 0);
        chk_regs("mrst");
        rst_n = 1'b1;

        load(3'd1, 16'h0005);
        load(3'd2, 16'h0005);
        do_cmd(3'd1, 3'd1, 3'd2, SH_NONE, ALU_SUB, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1);
        chk_flags("cmp", 1, 0, 0, 1);
        chk_regs("cmp");

        load(3'd3, 16'h0003);
        do_cmd(3'd6, 3'd3, 3'd2, SH_NONE, ALU_SUB, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1);
        exp_r[6] = 16'hFFFE;
        chk_flags("borrow", 0, 1, 0, 0);
        chk_regs("borrow");

        load(3'd2, 16'h8004);
        do_cmd(3'd5, 3'd0, 3'd2, SH_ASR, ALU_ADD, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0);
        exp_r[5] = 16'hC002;
        chk("asr dout", datapath_out, 16'hC002);
        chk_flags("asr", 0, 1, 0, 0);
        chk_regs("asr");

        sximm5 = 16'h0002;
        do_cmd(3'd4, 3'd5, 3'd0, SH_NONE, ALU_AND, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b1);
        exp_r[4] = 16'h0002;
        chk_flags("and", 0, 0, 0, 0);
        do_cmd(3'd7, 3'd0, 3'd2, SH_LSL, ALU_NOT, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1);
        exp_r[7] = 16'hFFF7;
        chk_flags("not", 0, 1, 0, 0);
        do_cmd(3'd3, 3'd0, 3'd2, SH_LSR, ALU_NOT, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0);
        exp_r[3] = 16'hBFFD;
        chk_regs("logic");

        mdata = 16'hABCD; sximm8 = 16'h1234; pc = 9'h1A5;
        do_cmd(3'd0, 3'd0, 3'd0, SH_NONE, ALU_ADD, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0);
        exp_r[0] = 16'hABCD;
        do_cmd(3'd1, 3'd0, 3'd0, SH_NONE, ALU_ADD, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b0);
        exp_r[1] = 16'h1234;
        do_cmd(3'd6, 3'd0, 3'd0, SH_NONE, ALU_ADD, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0);
        exp_r[6] = 16'h01A5;
        chk_regs("wbmux");

        // Second start during RDB must be dropped.
        @(negedge clk);
        sximm8 = 16'h0042; rd = 3'd0; vsel = 4'b0100; wb_en = 1'b1; flags_en = 1'b0;
        start = 1'b1;
        @(posedge clk);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == 1) begin
                start = 1'b1; rd = 3'd7; sximm8 = 16'h9999;
            end
            if (i == 2) begin
                start = 1'b0; rd = 3'd0; sximm8 = 16'h0042;
            end
            if (done) ndone++;
        end
        exp_r[0] = 16'h0042;
        chk("busy done count", 16'(ndone), 16'd1);
        chk_regs("busy");

        @(negedge clk);
        sximm8 = 16'h1111; rd = 3'd6; vsel = 4'b0100; wb_en = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        clear_model();
        chk("abort ready", {15'h0, ready}, 16'h1);
        chk("abort done", {15'h0, done}, 16'h0);
        @(negedge clk);
        chk("abort done wb", {15'h0, done}, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort done post", {15'h0, done}, 16'h0);
        chk("abort ready post", {15'h0, ready}, 16'h1);
        chk_regs("abort");

        load(3'd2, 16'h00A5);
        chk_regs("post abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
